ram_24_bit_4096_locations: RTL and testbench
============================================

Name: ram_24_bit_4096_locations

Overview:
- Single-port synchronous RAM: 4096 words × 24 bits, one clock domain.
- Used as a general data store for the datapath. A controller drives address, read enable and write enable each cycle.
- Read data is registered, so Dout changes only on a rising clk edge.

Parameters:
- DATA_WIDTH, 24, word width in bits.
- ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH = 4096.
- BANK_ADDR_WIDTH, 8, low address bits per bank.
  - The array is 2**(ADDR_WIDTH-BANK_ADDR_WIDTH) = 16 banks of 256 words.
  - The bank is selected by Address[11:8].

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Dout  output  24  registered read data.
- Address  input  12  word address, 0..4095.
- Write_Enable  input  1  write strobe, sampled at the rising clk edge.
- Din  input  24  write data.
- RE  input  1  read enable, sampled at the rising clk edge.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All inputs are sampled on the rising edge of clk. There are no combinational paths from inputs to Dout.
- Reset (reset=1 at an edge):
  - Dout <= 24'h000000.
  - Array contents are NOT cleared.
  - Write_Enable and RE are ignored in that cycle; no write occurs.
- Write (reset=0, Write_Enable=1):
  - mem[Address] <= Din at the edge.
  - The new value is readable from the next cycle.
- Read (reset=0, RE=1, Write_Enable=0): Dout <= mem[Address] at the edge. Read latency is one clock.
- Write with RE=1 (write-first):
  - mem[Address] <= Din and Dout <= Din in the same edge.
  - Dout never shows stale data for a written address.
- Write with RE=0: Dout holds its previous value.
- RE=0 and Write_Enable=0: no array change; Dout holds.
- Bank decode:
  - Exactly one bank is enabled per access, using Address[11:8].
  - Local offset within the bank is Address[7:0].
  - Unselected banks neither write nor drive the read mux.
  - The read mux selects the bank registered with the access, so Dout matches a flat 4096-entry memory exactly.
- Address range: the full 12-bit range is valid. There is no wrap or out-of-range case; 0 and 4095 are ordinary locations.
- Power-up: array contents are undefined until written. Dout is undefined until the first reset or read. Benches must write before reading.
- Write data is stored at full 24-bit width; there is no truncation or sign handling.

Test Plan:
- Basic write/read at 545:
  - Cycle 1: Write_Enable=1, Address=545, Din=64, RE=0.
  - Cycle 2: Write_Enable=0, RE=1, Address=545.
  - Required: Dout=24'd64 after the cycle-2 edge.
- Write-first at 721:
  - Cycle 1: Write_Enable=1, RE=1, Address=721, Din=78. Required: Dout=78 after that edge.
  - Cycle 2: Write_Enable=0, RE=1, Address=721. Required: Dout stays 78.
  - Then read 545. Required: Dout=64, proving no cross-location corruption.
- Boundaries and bank decode:
  - Write 24'hFFFFFF at 0, 24'hA5A5A5 at 4095, 24'h123456 at 255, 24'h654321 at 256.
  - Read each back. Required: exact values at one-cycle latency.
- Hold behaviour: after reading 545 (Dout=64), drive RE=0 with Address=721 for 3 cycles -> Dout remains 64.
- Reset:
  - With Dout=64, assert reset for one edge. Required: Dout=0.
  - Hold Write_Enable=1, Din=99, Address=545 during reset, then deassert reset and read 545. Required: Dout=64, proving contents are preserved and the write was blocked.
- Back-to-back traffic:
  - Alternate write/read every cycle across 16 addresses, one per bank (Address = k*256 + k, Din = k*1000).
  - Read all back. Required: every Dout equals k*1000 one cycle after its read request.

Source files
------------

// File: rtl/ram_24_bit_4096_locations.sv
// ram_24_bit_4096_locations: banked single-port RAM with registered, write-first read data
module ram_24_bit_4096_locations #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Dout,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  Write_Enable,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic                  RE
);
  localparam int SW = ADDR_WIDTH - BANK_ADDR_WIDTH;
  localparam int NB = 2 ** SW;
  localparam int BD = 2 ** BANK_ADDR_WIDTH;
  logic [SW-1:0] bank, bank_q;
  logic [BANK_ADDR_WIDTH-1:0] off;
  logic clr_q;
  logic [DATA_WIDTH-1:0] bank_rd [NB];
  assign bank = Address[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  assign off = Address[BANK_ADDR_WIDTH-1:0];
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BD];
    logic sel;
    assign sel = !reset && bank == SW'(b);
    always_ff @(posedge clk) begin
      if (sel && Write_Enable) mem[off] <= Din;
      if (sel && RE) bank_rd[b] <= Write_Enable ? Din : mem[off];
    end
  end
  // each bank holds its last read word; Dout follows the bank of the latest read
  always_ff @(posedge clk) begin
    if (reset) clr_q <= 1'b1;
    else if (RE) begin
      clr_q <= 1'b0;
      bank_q <= bank;
    end
  end
  assign Dout = clr_q ? '0 : bank_rd[bank_q];
endmodule

// File: tb/tb_ram_24_bit_4096_locations.sv
// tb_ram_24_bit_4096_locations: directed table-driven check of the banked RAM
module tb_ram_24_bit_4096_locations;
  logic clk = 1'b0;
  logic reset, Write_Enable, RE;
  logic [11:0] Address;
  logic [23:0] Din, Dout;
  int total = 0, bad = 0;

  ram_24_bit_4096_locations dut (
    .clk(clk), .reset(reset), .Dout(Dout), .Address(Address),
    .Write_Enable(Write_Enable), .Din(Din), .RE(RE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [23:0] din;
    logic [23:0] exp;
  } vec_t;

  vec_t tv [20];

  task automatic step(input logic rst, input logic we, input logic re,
                      input logic [11:0] addr, input logic [23:0] din);
    @(negedge clk);
    reset = rst; Write_Enable = we; RE = re; Address = addr; Din = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [23:0] exp);
    total++;
    if (Dout !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: Dout=%h expected=%h", name, idx, Dout, exp);
    end
  endtask

  initial begin
    reset = 1'b0; Write_Enable = 1'b0; RE = 1'b0; Address = '0; Din = '0;
    tv[0]  = '{"reset_state",  1'b1, 1'b0, 1'b0, 12'd0,    24'd0,       24'd0};
    tv[1]  = '{"write_545",    1'b0, 1'b1, 1'b0, 12'd545,  24'd64,      24'd0};
    tv[2]  = '{"read_545",     1'b0, 1'b0, 1'b1, 12'd545,  24'd0,       24'd64};
    tv[3]  = '{"wfirst_721",   1'b0, 1'b1, 1'b1, 12'd721,  24'd78,      24'd78};
    tv[4]  = '{"read_721",     1'b0, 1'b0, 1'b1, 12'd721,  24'd0,       24'd78};
    tv[5]  = '{"reread_545",   1'b0, 1'b0, 1'b1, 12'd545,  24'd0,       24'd64};
    tv[6]  = '{"write_0",      1'b0, 1'b1, 1'b0, 12'd0,    24'hFFFFFF,  24'd64};
    tv[7]  = '{"write_4095",   1'b0, 1'b1, 1'b0, 12'd4095, 24'hA5A5A5,  24'd64};
    tv[8]  = '{"write_255",    1'b0, 1'b1, 1'b0, 12'd255,  24'h123456,  24'd64};
    tv[9]  = '{"write_256",    1'b0, 1'b1, 1'b0, 12'd256,  24'h654321,  24'd64};
    tv[10] = '{"read_0",       1'b0, 1'b0, 1'b1, 12'd0,    24'd0,       24'hFFFFFF};
    tv[11] = '{"read_4095",    1'b0, 1'b0, 1'b1, 12'd4095, 24'd0,       24'hA5A5A5};
    tv[12] = '{"read_255",     1'b0, 1'b0, 1'b1, 12'd255,  24'd0,       24'h123456};
    tv[13] = '{"read_256",     1'b0, 1'b0, 1'b1, 12'd256,  24'd0,       24'h654321};
    tv[14] = '{"read_545_b",   1'b0, 1'b0, 1'b1, 12'd545,  24'd0,       24'd64};
    tv[15] = '{"hold",         1'b0, 1'b0, 1'b0, 12'd721,  24'd0,       24'd64};
    tv[16] = '{"hold",         1'b0, 1'b0, 1'b0, 12'd721,  24'd0,       24'd64};
    tv[17] = '{"hold",         1'b0, 1'b0, 1'b0, 12'd721,  24'd0,       24'd64};
    tv[18] = '{"reset_blocks", 1'b1, 1'b1, 1'b1, 12'd545,  24'd99,      24'd0};
    tv[19] = '{"after_reset",  1'b0, 1'b0, 1'b1, 12'd545,  24'd0,       24'd64};
    for (int i = 0; i < 20; i++) begin
      step(tv[i].rst, tv[i].we, tv[i].re, tv[i].addr, tv[i].din);
      chk(tv[i].name, i, tv[i].exp);
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 1'b0, 12'(k * 257), 24'(k * 1000));
      step(1'b0, 1'b0, 1'b1, 12'(k * 257), 24'd0);
      chk("b2b_read", k, 24'(k * 1000));
    end
    for (int k = 15; k >= 0; k--) begin
      step(1'b0, 1'b0, 1'b1, 12'(k * 257), 24'd0);
      chk("readback", k, 24'(k * 1000));
    end
    step(1'b0, 1'b1, 1'b0, 12'd3855, 24'h00ABCD);
    chk("write_no_re_hold", 0, 24'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
